// File: rtl/param_sync_fifo.sv
// Synchronous single-clock FIFO with registered occupancy, threshold flags,
// sticky error flags and a selectable standard / first-word-fall-through read port.
module param_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int FWFT   = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_vld,
   input  logic [ADDR_W:0]   cfg_almost_full,
   input  logic [ADDR_W:0]   cfg_almost_empty,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   fifo_num,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr, cnt;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              wr_acc, rd_acc;

   assign wr_addr = wr_ptr[ADDR_W-1:0];
   assign rd_addr = rd_ptr[ADDR_W-1:0];

   // Flags come only from the registered count, never from this cycle's wr/rd.
   assign full         = (cnt == DEPTH_N);
   assign empty        = (cnt == '0);
   assign almost_full  = (cnt >= cfg_almost_full);
   assign almost_empty = (cnt <= cfg_almost_empty);
   assign fifo_num     = cnt;

   assign wr_acc = wr & ~full  & ~clr;
   assign rd_acc = rd & ~empty & ~clr;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE;
         if (rd_acc) rd_ptr <= rd_ptr + ONE;
         if (wr_acc && !rd_acc)      cnt <= cnt + ONE;
         else if (rd_acc && !wr_acc) cnt <= cnt - ONE;
         if (wr && full)  overflow  <= 1'b1;
         if (rd && empty) underflow <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data     = mem[rd_addr];
         assign rd_data_vld = ~empty;
      end else begin : g_std
         logic [DATA_W-1:0] rd_q;
         logic              vld_q;

         // rd_q is held across clr so the last word read stays visible.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               rd_q  <= '0;
               vld_q <= 1'b0;
            end else if (clr) begin
               vld_q <= 1'b0;
            end else begin
               vld_q <= rd_acc;
               if (rd_acc) rd_q <= mem[rd_addr];
            end
         end

         assign rd_data     = rd_q;
         assign rd_data_vld = vld_q;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized scoreboard bench: drives a standard-mode and an FWFT-mode FIFO with
// identical stimulus and checks both against a queue-based reference model.
module tb_param_sync_fifo;
   localparam int DW = 32, DEPTH = 32, AW = 5;

   logic          clk, rstn, clr, wr, rd;
   logic [DW-1:0] wr_data;
   logic [AW:0]   cfg_af, cfg_ae;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          vld0, full0, empty0, af0, ae0, ovf0, udf0;
   logic          vld1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [AW:0]   num0, num1;

   param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .FWFT(0)) u_std (
      .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .wr_data(wr_data), .rd(rd),
      .rd_data(rd_data0), .rd_data_vld(vld0),
      .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .fifo_num(num0), .overflow(ovf0), .underflow(udf0));

   param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .FWFT(1)) u_fwft (
      .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .wr_data(wr_data), .rd(rd),
      .rd_data(rd_data1), .rd_data_vld(vld1),
      .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .fifo_num(num1), .overflow(ovf1), .underflow(udf1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model: contents queue plus expected-response queues
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp0[$];
   logic [DW-1:0] exp1[$];
   bit            m_ovf, m_udf, m_vld0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      int n;
      n = mq.size();
      chk("fifo_num std",   num0, n);
      chk("fifo_num fwft",  num1, n);
      chk("full std",       full0, n == DEPTH);
      chk("full fwft",      full1, n == DEPTH);
      chk("empty std",      empty0, n == 0);
      chk("empty fwft",     empty1, n == 0);
      chk("almost_full std",   af0, n >= int'(cfg_af));
      chk("almost_full fwft",  af1, n >= int'(cfg_af));
      chk("almost_empty std",  ae0, n <= int'(cfg_ae));
      chk("almost_empty fwft", ae1, n <= int'(cfg_ae));
      chk("overflow std",   ovf0, m_ovf);
      chk("overflow fwft",  ovf1, m_ovf);
      chk("underflow std",  udf0, m_udf);
      chk("underflow fwft", udf1, m_udf);
      chk("rd_data_vld std",  vld0, m_vld0);
      chk("rd_data_vld fwft", vld1, n != 0);
   endtask

   task automatic model_edge(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
      bit f, e, wa, ra;
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (c) begin
         mq.delete();
         exp1.delete();
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_vld0 = 1'b0;
      end else begin
         wa = w && !f;
         ra = r && !e;
         if (w && f) m_ovf = 1'b1;
         if (r && e) m_udf = 1'b1;
         m_vld0 = ra;
         if (ra) exp0.push_back(mq.pop_front());
         if (wa) begin
            mq.push_back(d);
            exp1.push_back(d);
         end
      end
   endtask

   // inputs are applied 1 time unit after an edge, model updated at the next edge
   task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
      wr = w; rd = r; clr = c; wr_data = d;
      @(posedge clk);
      model_edge(w, r, c, d);
      #1;
      check_status();
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
      #1;
      mq.delete(); exp0.delete(); exp1.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_vld0 = 1'b0;
      check_status();
      chk("rd_data std in reset", rd_data0, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // monitor: pops expected words whenever a DUT presents read data
   always @(negedge clk) begin
      if (rstn) begin
         if (vld0) begin
            if (exp0.size() == 0) chk("spurious rd_data_vld std", 1, 0);
            else                  chk("rd_data std", rd_data0, exp0.pop_front());
         end
         if (vld1 && rd && !clr) begin
            if (exp1.size() == 0) chk("spurious pop fwft", 1, 0);
            else                  chk("rd_data fwft", rd_data1, exp1.pop_front());
         end
      end
   end

   initial begin
      wr = 1'b0; rd = 1'b0; clr = 1'b0; wr_data = '0;
      cfg_af = 6'd28; cfg_ae = 6'd3;
      do_reset();

      // fill to full, one overflowing write, then drain in order
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, i);
      step(1, 0, 0, 32'hDEAD_BEEF);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      // simultaneous wr/rd at empty and at full
      step(1, 1, 0, 32'h7);
      for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 32'h100 + i);
      step(1, 1, 0, 32'h5555);

      // steady occupancy of 10 across pointer wraps
      step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom);
      for (int i = 0; i < 100; i++) step(1, 1, 0, $urandom);

      // clr with a concurrent write at fifo_num=5 and overflow set
      step(0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h200 + i);
      step(1, 0, 0, 32'hBAD);
      for (int i = 0; i < DEPTH - 5; i++) step(0, 1, 0, 0);
      step(1, 0, 1, 32'hC1C1);
      step(1, 0, 0, 32'h1234);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      // FWFT head visibility on a write into empty
      step(1, 0, 0, 32'hA5);
      chk("fwft head after write", rd_data1, 32'hA5);
      step(0, 1, 0, 0);

      // reset mid-operation discards stored words
      for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h300 + i);
      do_reset();
      step(1, 0, 0, 32'hF00D);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      // randomized phases alternating write-heavy and read-heavy bias
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 99) == 0) begin
               cfg_af = 6'($urandom_range(0, 40));
               cfg_ae = 6'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            else step($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 30),
                      $urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 75),
                      $urandom_range(0, 199) == 0, $urandom);
         end
      end

      // drain and confirm every expected word was delivered
      for (int i = 0; i < DEPTH && mq.size() > 0; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("std words outstanding", exp0.size(), 0);
      chk("fwft words outstanding", exp1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of words; power of two and at least 4.
REQ-003 SHALL have parameter ADDR_W, default 5: log2(DEPTH); occupancy and threshold ports are ADDR_W+1 bits wide.
REQ-004 SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-008 SHALL have port wr, input, 1 bit: write request.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 SHALL have port rd, input, 1 bit: read request (pop).
REQ-011 SHALL have port rd_data, output, DATA_W bits: read data.
REQ-012 SHALL have port rd_data_vld, output, 1 bit: rd_data valid.
REQ-013 SHALL have ports cfg_almost_full and cfg_almost_empty, input, ADDR_W+1 bits each: occupancy thresholds.
REQ-014 SHALL have ports full, empty, almost_full and almost_empty, output, 1 bit each: status flags.
REQ-015 SHALL have port fifo_num, output, ADDR_W+1 bits: current occupancy, 0..DEPTH.
REQ-016 SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-017 SHALL keep write and read pointers ADDR_W+1 bits wide and address storage with the low ADDR_W bits, wrapping modulo DEPTH.
REQ-018 SHALL accept a write (wr_acc) iff wr=1 and full=0, storing wr_data at the write pointer and incrementing the write pointer at that edge.
REQ-019 SHALL accept a read (rd_acc) iff rd=1 and empty=0, incrementing the read pointer at that edge.
REQ-020 SHALL never accept a write when full, even if rd=1 in the same cycle, and never accept a read when empty, even if wr=1 in the same cycle.
REQ-021 SHALL register fifo_num and update it per edge: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-022 SHALL derive flags combinationally from registered fifo_num only, not from wr or rd: full = (fifo_num==DEPTH); empty = (fifo_num==0); almost_full = (fifo_num >= cfg_almost_full); almost_empty = (fifo_num <= cfg_almost_empty).
REQ-023 FWFT=0: on rd_acc, SHALL register the word at the read pointer into rd_data at that edge and assert rd_data_vld for exactly the following cycle (latency 1), and SHALL hold rd_data when there is no rd_acc.
REQ-024 FWFT=1: rd_data SHALL present the head word (storage at the read pointer) combinationally and rd_data_vld = ~empty; rd=1 with rd_data_vld=1 pops the head, and the next word or the empty state is visible in the next cycle.
REQ-025 FWFT=1: a word written into an empty FIFO SHALL appear on rd_data with rd_data_vld=1 in the cycle after the write edge.
REQ-026 SHALL set overflow on any edge with wr=1 and full=1, and SHALL set underflow on any edge with rd=1 and empty=1; both remain set until clr or reset.
REQ-027 SHALL give clr=1 priority over wr and rd: at that edge, pointers, fifo_num, overflow and underflow go to 0, rd_data_vld (FWFT=0) goes to 0, no write or read is accepted, and storage contents and rd_data (FWFT=0) are unchanged.
REQ-028 SHALL leave storage unreset; rd_data in FWFT=1 is don't-care whenever rd_data_vld=0.

Reset
REQ-029 On rstn low, SHALL immediately set pointers=0, fifo_num=0, overflow=0, underflow=0, rd_data_vld=0 and rd_data=0 (FWFT=0), giving empty=1 and full=0.
REQ-030 Assertion of rstn mid-operation SHALL discard all stored words, and the first write after release SHALL be read first.

Verification
REQ-031 FWFT=0, DEPTH=32: write 0..31 on consecutive cycles -> full=1 and fifo_num=32 after 32nd edge; 33rd write -> overflow=1, fifo_num stays 32; read 32 -> data 0..31 in order, each one cycle after rd.
REQ-032 Empty FIFO, wr=1 and rd=1 same cycle -> write accepted, read rejected, fifo_num=1, underflow=1; with fifo_num=32 and wr=rd=1 -> read only, fifo_num=31, overflow=1.
REQ-033 fifo_num=10, wr=rd=1 for 100 cycles -> fifo_num stays 10, pointers wrap at least 3 times, data order preserved.
REQ-034 cfg_almost_full=28, cfg_almost_empty=3: fill 0->32 -> almost_empty is 1 for fifo_num 0..3, and almost_full goes 1 at fifo_num=28.
REQ-035 FWFT=1: write 0xA5 into empty FIFO -> next cycle rd_data=0xA5 and rd_data_vld=1; rd=1 -> next cycle rd_data_vld=0 and empty=1.
REQ-036 fifo_num=5 with overflow=1, clr=1 together with wr=1 -> next cycle fifo_num=0, empty=1, overflow=0, and no word is stored.
